joystick_scanner: RTL
=====================

# joystick_scanner

Front-end input stage for the two-player fighting game. It polls the four joystick channels through the XADC dynamic reconfiguration port (DRP) in a fixed round-robin and decodes each 4-bit stick reading into per-player movement deltas and kick flags. It then presents them as a frame-stable snapshot, updated on the falling edge of v_sync. Its outputs feed the player-position update and sprite-select logic directly.

## Interface
Parameters:
- SETTLE_CYCLES, 64: idle cycles after each channel switch before the DRP read is issued; legal range 1..1023.
- TIMEOUT_CYCLES, 255: maximum wait for drp_drdy after drp_den.
- DEADBAND, 0: stick nibble tolerance around centre value 8; legal range 0..7.
- STEP, 1: magnitude of a deflected dx/dy (11-bit signed).
- GRAVITY_DY, 5: dy value when the vertical stick is neutral.

Ports. One clock; reset is synchronous and active-low.
- clk, in, 1: system clock, also the clock of gen_sync.
- rst_n, in, 1: synchronous, active-low reset.
- v_sync, in, 1: from gen_sync in the same domain; no synchronizer.
- drp_daddr, out, 7: XADC DRP address.
- drp_den, out, 1: DRP enable; single-cycle pulse.
- drp_drdy, in, 1: DRP data-ready.
- drp_do, in, 16: DRP read data; only [15:12] is used.
- p1_dx, p1_dy, p2_dx, p2_dy, out, 11 each (signed): per-frame deltas.
- p1_kick, p2_kick, out, 1 each: kick requested.
- frame_valid, out, 1: one-cycle pulse when the outputs were just updated from a new scan.
- adc_err, out, 1: sticky flag; set on any DRP timeout and cleared only by reset.

## Operation
- Channel order is fixed: idx0 = 0x16 (P1 X), idx1 = 0x1E (P1 Y), idx2 = 0x17 (P2 X), idx3 = 0x1F (P2 Y). After idx3 the scan wraps to idx0.
- FSM states: SETTLE → REQ → WAIT → DECODE → SETTLE.
  - SETTLE: drp_daddr is driven with the current channel address. A counter runs for SETTLE_CYCLES cycles.
  - REQ: drp_den = 1 for exactly one cycle.
  - WAIT: the FSM holds until drp_drdy = 1, then latches n = drp_do[15:12]. If TIMEOUT_CYCLES cycles elapse without drp_drdy, it uses n = 8 and sets adc_err.
  - DECODE: writes the staged result for the current channel, advances the index, and returns to SETTLE. On the idx3 decode it also sets the internal scan_ready flag.
- X decode: n > 8+DEADBAND gives +STEP; n < 8−DEADBAND gives −STEP; otherwise 0.
- Y decode:
  - n > 8+DEADBAND: dy = +STEP, kick = 0.
  - n < 8−DEADBAND: dy = 0, kick = 1.
  - otherwise: dy = GRAVITY_DY, kick = 0.
- All 4-bit comparisons are unsigned. Deltas are sign-extended to 11 bits.
- drp_drdy seen in any state other than WAIT is ignored.
- Frame snapshot:
  - Falling edge is detected as v_sync_q = 1 and v_sync = 0, where v_sync_q is the registered v_sync.
  - On the edge, if scan_ready = 1, all staged values are copied to the outputs, frame_valid pulses, and scan_ready clears.
  - On the edge, if scan_ready = 0, the outputs hold and frame_valid stays 0.
- Simultaneous events: if the idx3 decode and a v_sync edge land in the same cycle, the snapshot takes the pre-cycle staged and scan_ready values. The new scan is published at the next edge.

## Timing
- Reset values:
  - all deltas 0, kicks 0, frame_valid 0, adc_err 0;
  - drp_den 0, drp_daddr 0x16;
  - state SETTLE with counter 0, idx 0, staged values 0, scan_ready 0;
  - v_sync_q 1, so no spurious edge is seen after reset.
- Reset asserted mid-scan abandons the pending read. A late drp_drdy arriving after reset is ignored, since the FSM is not in WAIT.
- Per-channel latency is SETTLE_CYCLES + 1 (REQ) + k (WAIT, 1 ≤ k ≤ TIMEOUT_CYCLES) + 1 (DECODE) cycles.
- A full scan is 4× the per-channel latency.
- Outputs change only in the cycle after a detected v_sync falling edge; frame_valid is high in that same cycle.
- Outputs are constant for the rest of the frame.

## Test plan
- Reset, then a DRP model that answers drp_drdy 3 cycles after drp_den with 0x8xxx on all channels. After the first v_sync fall: all dx = 0, all dy = 5, kicks 0, frame_valid pulses once.
- Return 0xF000 on 0x16, 0x1000 on 0x1E, 0x0000 on 0x17, 0xC000 on 0x1F. Next frame: p1_dx = +1, p1_kick = 1, p1_dy = 0, p2_dx = −1 (0x7FF), p2_dy = +1, p2_kick = 0.
- Check the address sequence: drp_daddr follows 16, 1E, 17, 1F, 16. drp_den is a single-cycle pulse issued exactly SETTLE_CYCLES cycles after each address change.
- Model never raises drp_drdy on 0x1E. Expect the WAIT timeout after 255 cycles, adc_err stuck at 1, p1_dy = 5, and the scan continuing to 0x17.
- Force the idx3 decode to coincide with a v_sync fall. Outputs keep the old snapshot and frame_valid = 0 if no earlier scan was ready. The new values appear at the following fall.
- Assert rst_n = 0 during WAIT and inject drp_drdy one cycle after release. All outputs are at reset values, the drp_drdy is ignored, and the scan restarts at 0x16.

Source files
------------

// File: rtl/joystick_scanner.sv
// XADC joystick poller: round-robin DRP reads of four stick channels, decoded
// into per-player deltas and kick flags, published as a v_sync-stable snapshot.
module joystick_scanner #(
  parameter int                 SETTLE_CYCLES  = 64,
  parameter int                 TIMEOUT_CYCLES = 255,
  parameter int                 DEADBAND       = 0,
  parameter logic signed [10:0] STEP           = 11'sd1,
  parameter logic signed [10:0] GRAVITY_DY     = 11'sd5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               v_sync,
  output logic [6:0]         drp_daddr,
  output logic               drp_den,
  input  logic               drp_drdy,
  input  logic [15:0]        drp_do,
  output logic signed [10:0] p1_dx,
  output logic signed [10:0] p1_dy,
  output logic signed [10:0] p2_dx,
  output logic signed [10:0] p2_dy,
  output logic               p1_kick,
  output logic               p2_kick,
  output logic               frame_valid,
  output logic               adc_err
);

  localparam int                CNT_W        = 16;
  localparam logic [CNT_W-1:0]  SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [4:0]        HI_TH        = 5'(8 + DEADBAND);
  localparam logic [4:0]        LO_TH        = 5'(8 - DEADBAND);

  typedef enum logic [1:0] {
    ST_SETTLE,
    ST_REQ,
    ST_WAIT,
    ST_DECODE
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [1:0]         idx;
  logic [3:0]         nib;
  logic               v_sync_q;
  logic               scan_ready;
  logic signed [10:0] stg_p1_dx, stg_p1_dy, stg_p2_dx, stg_p2_dy;
  logic               stg_p1_kick, stg_p2_kick;

  logic               wait_expired;
  logic               decode_last;
  logic               snap;
  logic signed [10:0] x_delta, y_delta;
  logic               y_kick;
  logic               unused_drp_bits;

  assign unused_drp_bits = ^drp_do[11:0];
  assign wait_expired    = (state == ST_WAIT) && !drp_drdy && (cnt == TIMEOUT_LAST);
  assign decode_last     = (state == ST_DECODE) && (idx == 2'd3);
  assign snap            = v_sync_q && !v_sync && scan_ready;

  always_comb begin
    drp_daddr = 7'h16;
    case (idx)
      2'd0: drp_daddr = 7'h16;
      2'd1: drp_daddr = 7'h1E;
      2'd2: drp_daddr = 7'h17;
      2'd3: drp_daddr = 7'h1F;
      default: drp_daddr = 7'h16;
    endcase
  end

  // NOTE: every signal written here is given a default first so no path leaves it unassigned and a latch is never inferred.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    drp_den   = 1'b0;
    case (state)
      ST_SETTLE: begin
        if (cnt == SETTLE_LAST) begin
          state_nxt = ST_REQ;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      ST_REQ: begin
        drp_den   = 1'b1;
        state_nxt = ST_WAIT;
        cnt_nxt   = '0;
      end
      ST_WAIT: begin
        if (drp_drdy || cnt == TIMEOUT_LAST) begin
          state_nxt = ST_DECODE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      ST_DECODE: begin
        state_nxt = ST_SETTLE;
        cnt_nxt   = '0;
      end
      default: begin
        state_nxt = ST_SETTLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // One decoder serves both axes; the Y meaning of "low" is a kick, not a move.
  always_comb begin
    x_delta = '0;
    y_delta = GRAVITY_DY;
    y_kick  = 1'b0;
    if ({1'b0, nib} > HI_TH) begin
      x_delta = STEP;
      y_delta = STEP;
    end else if ({1'b0, nib} < LO_TH) begin
      x_delta = -STEP;
      y_delta = '0;
      y_kick  = 1'b1;
    end
  end

  // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values, which is what makes a coincident decode and snapshot publish the old scan.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_SETTLE;
      cnt         <= '0;
      idx         <= '0;
      nib         <= 4'h8;
      v_sync_q    <= 1'b1;
      scan_ready  <= 1'b0;
      stg_p1_dx   <= '0;
      stg_p1_dy   <= '0;
      stg_p2_dx   <= '0;
      stg_p2_dy   <= '0;
      stg_p1_kick <= 1'b0;
      stg_p2_kick <= 1'b0;
      p1_dx       <= '0;
      p1_dy       <= '0;
      p2_dx       <= '0;
      p2_dy       <= '0;
      p1_kick     <= 1'b0;
      p2_kick     <= 1'b0;
      frame_valid <= 1'b0;
      adc_err     <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      v_sync_q <= v_sync;

      if (state == ST_WAIT) begin
        if (drp_drdy) begin
          nib <= drp_do[15:12];
        end else if (wait_expired) begin
          nib     <= 4'h8;
          adc_err <= 1'b1;
        end
      end

      if (state == ST_DECODE) begin
        idx <= idx + 2'd1;
        case (idx)
          2'd0: stg_p1_dx <= x_delta;
          2'd1: begin
            stg_p1_dy   <= y_delta;
            stg_p1_kick <= y_kick;
          end
          2'd2: stg_p2_dx <= x_delta;
          2'd3: begin
            stg_p2_dy   <= y_delta;
            stg_p2_kick <= y_kick;
          end
          default: ;
        endcase
      end

      // A freshly completed scan outranks the clear so it is still published at the next edge.
      if (decode_last) begin
        scan_ready <= 1'b1;
      end else if (snap) begin
        scan_ready <= 1'b0;
      end

      frame_valid <= snap;
      if (snap) begin
        p1_dx   <= stg_p1_dx;
        p1_dy   <= stg_p1_dy;
        p2_dx   <= stg_p2_dx;
        p2_dy   <= stg_p2_dy;
        p1_kick <= stg_p1_kick;
        p2_kick <= stg_p2_kick;
      end
    end
  end

endmodule
